// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared definitions for the I2S receive deserializer: slot polarity, FSM
// encoding and default geometry.
package i2s_rx_deserializer_pkg;

    localparam int DEF_SAMPLE_WIDTH  = 24;
    localparam int DEF_MIN_SLOT_BITS = 24;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2
    } rx_state_e;

    // Bits needed for a counter that must reach max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Codec-facing I2S lines plus the deserialised stereo output bundle.
interface i2s_rx_deserializer_if
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
);

    logic                    i2s_bclk;
    logic                    i2s_lr;
    logic                    i2s_sdata;
    logic [SAMPLE_WIDTH-1:0] sample_l;
    logic [SAMPLE_WIDTH-1:0] sample_r;
    logic                    new_sample;
    logic                    frame_error;

    // Codec side: drives the serial lines, consumes the words.
    modport master (
        output i2s_bclk, i2s_lr, i2s_sdata,
        input  sample_l, sample_r, new_sample, frame_error
    );

    // Deserializer side.
    modport slave (
        input  i2s_bclk, i2s_lr, i2s_sdata,
        output sample_l, sample_r, new_sample, frame_error
    );

endinterface

// File: rtl/i2s_rx_deserializer_sync_edge.sv
// Brings the asynchronous codec lines into the clk domain and produces a
// registered BCLK rising-edge pulse with LR/data aligned to it.
module i2s_rx_deserializer_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic bclk_raw,
    input  logic lr_raw,
    input  logic sdata_raw,
    output logic bclk_rise,
    output logic lr_level,
    output logic sdata_level
);

    logic [2:0] bclk_sync_r;
    logic [1:0] lr_sync_r;
    logic [1:0] sdata_sync_r;
    logic       bclk_rise_r;
    logic       lr_level_r;
    logic       sdata_level_r;

    // Two-flop synchronisers, then one more stage so level and pulse stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync_r   <= 3'b000;
            lr_sync_r     <= 2'b00;
            sdata_sync_r  <= 2'b00;
            bclk_rise_r   <= 1'b0;
            lr_level_r    <= 1'b0;
            sdata_level_r <= 1'b0;
        end else begin
            bclk_sync_r   <= {bclk_sync_r[1:0], bclk_raw};
            lr_sync_r     <= {lr_sync_r[0], lr_raw};
            sdata_sync_r  <= {sdata_sync_r[0], sdata_raw};
            bclk_rise_r   <= bclk_sync_r[1] & ~bclk_sync_r[2];
            lr_level_r    <= lr_sync_r[1];
            sdata_level_r <= sdata_sync_r[1];
        end
    end

    assign bclk_rise   = bclk_rise_r;
    assign lr_level    = lr_level_r;
    assign sdata_level = sdata_level_r;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: deserialises the codec ADC stream into left/right PCM words
// and presents one stereo pair per frame with a single-cycle strobe.
module i2s_rx_deserializer
    import i2s_rx_deserializer_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter int MIN_SLOT_BITS = DEF_MIN_SLOT_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    i2s_rx_deserializer_if.slave  bus
);

    localparam int CNT_W = cnt_width(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_SLOT_BITS);

    logic                    bclk_rise_s;
    logic                    lr_s;
    logic                    sdata_s;
    logic                    lr_edge_s;
    logic [SAMPLE_WIDTH-1:0] word_next_s;

    rx_state_e               state_r;
    logic                    lr_prev_r;
    logic                    lr_seen_r;
    logic [SAMPLE_WIDTH-2:0] shift_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [SAMPLE_WIDTH-1:0] hold_l_r;
    logic                    left_valid_r;
    logic [SAMPLE_WIDTH-1:0] sample_l_r;
    logic [SAMPLE_WIDTH-1:0] sample_r_r;
    logic                    new_sample_r;
    logic                    frame_error_r;

    i2s_rx_deserializer_sync_edge u_sync (
        .clk         (clk),
        .reset       (reset),
        .bclk_raw    (bus.i2s_bclk),
        .lr_raw      (bus.i2s_lr),
        .sdata_raw   (bus.i2s_sdata),
        .bclk_rise   (bclk_rise_s),
        .lr_level    (lr_s),
        .sdata_level (sdata_s)
    );

    // LR transitions only count once a reference LR value exists, so a reset
    // released mid-slot never mistakes the current slot for a fresh one.
    always_comb begin
        lr_edge_s   = bclk_rise_s & lr_seen_r & (lr_s ^ lr_prev_r);
        word_next_s = {shift_r, sdata_s};
    end

    // Slot FSM, shift register and registered outputs, stepped on BCLK rises.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_HUNT;
            lr_prev_r     <= 1'b0;
            lr_seen_r     <= 1'b0;
            shift_r       <= '0;
            bit_cnt_r     <= CNT_ZERO;
            hold_l_r      <= '0;
            left_valid_r  <= 1'b0;
            sample_l_r    <= '0;
            sample_r_r    <= '0;
            new_sample_r  <= 1'b0;
            frame_error_r <= 1'b0;
        end else begin
            new_sample_r  <= 1'b0;
            frame_error_r <= 1'b0;
            if (bclk_rise_s) begin
                lr_prev_r <= lr_s;
                lr_seen_r <= 1'b1;
                case (state_r)
                    // The LR-edge rise is itself the I2S delay bit, so DELAY
                    // is passed through within that same step.
                    ST_HUNT: begin
                        if (lr_edge_s) begin
                            state_r   <= ST_SHIFT;
                            bit_cnt_r <= CNT_ZERO;
                        end
                    end
                    ST_DELAY: begin
                        state_r   <= ST_SHIFT;
                        bit_cnt_r <= CNT_ZERO;
                    end
                    ST_SHIFT: begin
                        if (lr_edge_s) begin
                            if (bit_cnt_r < CNT_MIN) begin
                                frame_error_r <= 1'b1;
                                left_valid_r  <= 1'b0;
                            end
                            bit_cnt_r <= CNT_ZERO;
                        end else if (bit_cnt_r < CNT_FULL) begin
                            shift_r   <= word_next_s[SAMPLE_WIDTH-2:0];
                            bit_cnt_r <= bit_cnt_r + CNT_ONE;
                            if (bit_cnt_r == CNT_LAST) begin
                                if (lr_s == LR_LEFT) begin
                                    hold_l_r     <= word_next_s;
                                    left_valid_r <= 1'b1;
                                end else if (left_valid_r) begin
                                    sample_l_r   <= hold_l_r;
                                    sample_r_r   <= word_next_s;
                                    new_sample_r <= 1'b1;
                                    left_valid_r <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r   <= ST_HUNT;
                        bit_cnt_r <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    assign bus.sample_l    = sample_l_r;
    assign bus.sample_r    = sample_r_r;
    assign bus.new_sample  = new_sample_r;
    assign bus.frame_error = frame_error_r;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed + random bench for i2s_rx_deserializer; expected stereo pairs are
// queued as frames are driven and compared when the strobe appears.
module tb_i2s_rx_deserializer;
    import i2s_rx_deserializer_pkg::*;

    localparam int SW         = 24;
    localparam int HALF_CLK   = 5;
    localparam int HALF_BCLK  = 40;
    localparam int N_RAND     = 120;

    typedef struct packed {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } pair_t;

    logic  clk = 1'b0;
    logic  reset;
    pair_t sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ns_cnt = 0;
    int    fe_cnt = 0;
    int    clk_edges = 0;
    int    lsb_snap = 0;
    int    base_ns;

    i2s_rx_deserializer_if #(.SAMPLE_WIDTH(SW)) bus ();

    i2s_rx_deserializer #(.SAMPLE_WIDTH(SW), .MIN_SLOT_BITS(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #HALF_CLK clk = ~clk;

    always @(posedge clk) clk_edges <= clk_edges + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One slot: delay bit, MSB-first word, then padding bits.
    task automatic send_slot(input logic lr, input logic [SW-1:0] w, input int nbits,
                             input logic pad, input logic mark);
        for (int i = 0; i < nbits; i++) begin
            logic bit_v;
            if (i >= 1 && i <= SW) bit_v = w[SW - i];
            else                   bit_v = pad;
            bus.i2s_bclk  = 1'b0;
            bus.i2s_lr    = lr;
            bus.i2s_sdata = bit_v;
            #(HALF_BCLK);
            bus.i2s_bclk = 1'b1;
            if (mark && i == SW) lsb_snap = clk_edges;
            #(HALF_BCLK);
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r, input int nbits,
                              input logic pad, input logic push);
        if (push) sb_q.push_back({l, r});
        send_slot(LR_LEFT, l, nbits, pad, 1'b0);
        send_slot(LR_RIGHT, r, nbits, pad, 1'b1);
    endtask

    // Keep BCLK edges off the clk edges with a random sub-period offset.
    task automatic rephase();
        int p;
        p = int'($urandom_range(1, 8));
        if (p >= 5) p = p + 1;
        @(negedge clk);
        #(p);
    endtask

    task automatic settle();
        repeat (8) @(negedge clk);
    endtask

    task automatic monitor_loop();
        logic  prev_ns = 1'b0;
        logic  prev_fe = 1'b0;
        pair_t exp_p;
        forever begin
            @(negedge clk);
            if (bus.new_sample) begin
                ns_cnt++;
                chk("strobe_excl_ferr", bus.frame_error, 0);
                chk("strobe_width", prev_ns, 0);
                chk("strobe_expected", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_p = sb_q.pop_front();
                    chk("sample_l", bus.sample_l, exp_p.l);
                    chk("sample_r", bus.sample_r, exp_p.r);
                    chk("latency", clk_edges - lsb_snap, 4);
                end
            end
            if (bus.frame_error) begin
                fe_cnt++;
                chk("ferr_width", prev_fe, 0);
            end
            prev_ns = bus.new_sample;
            prev_fe = bus.frame_error;
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.i2s_bclk  = 1'b0;
        bus.i2s_lr    = 1'b0;
        bus.i2s_sdata = 1'b0;
        fork
            monitor_loop();
        join_none

        repeat (4) @(negedge clk);
        chk("rst_sample_l", bus.sample_l, 0);
        chk("rst_sample_r", bus.sample_r, 0);
        chk("rst_new_sample", bus.new_sample, 0);
        chk("rst_frame_error", bus.frame_error, 0);
        reset = 1'b0;

        // 64-fs frames; the first frame only locks on.
        rephase();
        send_frame(24'h123456, 24'hABCDEF, 32, 1'b0, 1'b0);
        send_frame(24'h123456, 24'hABCDEF, 32, 1'b0, 1'b1);
        send_frame(24'h123456, 24'hABCDEF, 32, 1'b0, 1'b1);
        settle();
        chk("t1_strobes", ns_cnt, 2);
        chk("t1_hold_l", bus.sample_l, 24'h123456);
        chk("t1_hold_r", bus.sample_r, 24'hABCDEF);

        // Extremes with 32-bit slots padded with ones.
        rephase();
        send_frame(24'h800000, 24'h7FFFFF, 32, 1'b1, 1'b1);
        send_frame(24'h800000, 24'h7FFFFF, 32, 1'b1, 1'b1);
        settle();
        chk("t2_strobes", ns_cnt, 4);
        chk("t2_no_ferr", fe_cnt, 0);
        chk("t2_hold_l", bus.sample_l, 24'h800000);

        // Short left slot (10 data bits), then a clean frame.
        rephase();
        send_slot(LR_LEFT, 24'h0ABCDE, 11, 1'b0, 1'b0);
        send_slot(LR_RIGHT, 24'h0F0F0F, 32, 1'b0, 1'b1);
        settle();
        chk("t3_ferr", fe_cnt, 1);
        chk("t3_no_strobe", ns_cnt, 4);
        send_frame(24'h000001, 24'hFFFFFE, 32, 1'b0, 1'b1);
        settle();
        chk("t3_strobes", ns_cnt, 5);
        chk("t3_hold_r", bus.sample_r, 24'hFFFFFE);

        // Reset in the middle of a right slot, held for 20 cycles.
        rephase();
        fork
            send_frame(24'h5A5A5A, 24'hC3C3C3, 32, 1'b0, 1'b0);
            begin
                #(2 * HALF_BCLK * 42);
                reset = 1'b1;
                repeat (20) @(negedge clk);
                reset = 1'b0;
            end
        join
        chk("t4_rst_l", bus.sample_l, 0);
        chk("t4_rst_r", bus.sample_r, 0);
        chk("t4_no_strobe", ns_cnt, 5);
        send_frame(24'h2468AC, 24'h13579B, 32, 1'b0, 1'b1);
        settle();
        chk("t4_strobes", ns_cnt, 6);
        chk("t4_ferr", fe_cnt, 1);
        chk("t4_hold_l", bus.sample_l, 24'h2468AC);

        // Random frames at full BCLK rate with phase jitter between frames.
        bus.i2s_bclk = 1'b0;
        bus.i2s_lr   = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_l", bus.sample_l, 0);
        base_ns = ns_cnt;
        rephase();
        for (int f = 0; f < N_RAND; f++) begin
            logic [SW-1:0] l_v;
            logic [SW-1:0] r_v;
            l_v = SW'($urandom());
            r_v = SW'($urandom());
            #(5 * int'($urandom_range(0, 3)));
            send_frame(l_v, r_v, 25, 1'b0, f > 0);
        end
        settle();
        chk("t5_strobes", ns_cnt - base_ns, N_RAND - 1);
        chk("t5_ferr", fe_cnt, 1);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
